// File: rtl/lcd_char_driver.sv
// HD44780 4-bit write-only driver: power-on init once, then paints a 32-char
// frame (two 16-char lines) automatically and again on every refresh request.
module lcd_char_driver #(
  parameter int POWERUP_CYCLES = 1500000,
  parameter int INIT_WAIT      = 410000,
  parameter int E_PULSE_CYCLES = 25,
  parameter int NIBBLE_GAP     = 100,
  parameter int CMD_WAIT       = 4000,
  parameter int CLEAR_WAIT     = 164000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         refresh,
  input  logic [255:0] strdata,
  output logic         busy,
  output logic         frame_done,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [3:0]   lcd_dat
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(POWERUP_CYCLES, INIT_WAIT), max2(E_PULSE_CYCLES, NIBBLE_GAP)),
                             max2(CMD_WAIT, CLEAR_WAIT));
  localparam int CW   = $clog2(MAXP + 1);

  typedef enum logic [3:0] {
    S_POWERUP, S_WAKE, S_CFG, S_LATCH, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_DONE, S_IDLE
  } state_t;

  // Every nibble runs setup -> pulse -> hold -> wait; the wait after a high
  // nibble is the inter-nibble gap, after the final nibble it is the command wait.
  typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD, P_WAIT} phase_t;

  state_t         state, state_n;
  phase_t         phase, phase_n;
  logic           lo, lo_n;
  logic [1:0]     step, step_n;
  logic [4:0]     idx, idx_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           pending, pending_n;
  logic           load;
  logic [255:0]   frame;

  logic           xfer_state;
  logic [7:0]     cur_byte;
  logic           cur_rs;
  logic           nib_only;
  logic [3:0]     wake_nib;
  logic [3:0]     nibble;
  logic [CW-1:0]  end_wait;
  logic [CW-1:0]  wait_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_POWERUP;
      phase   <= P_SETUP;
      lo      <= 1'b0;
      step    <= 2'd0;
      idx     <= 5'd0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      lo      <= lo_n;
      step    <= step_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      if (load) frame <= strdata;
    end
  end

  // Byte/nibble selection for whichever transfer state is active.
  always_comb begin
    xfer_state = (state == S_WAKE) || (state == S_CFG) || (state == S_ADDR1) ||
                 (state == S_LINE1) || (state == S_ADDR2) || (state == S_LINE2);
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    nib_only = 1'b0;
    wake_nib = 4'h3;
    end_wait = CW'(CMD_WAIT);
    case (state)
      S_WAKE: begin
        nib_only = 1'b1;
        wake_nib = (step == 2'd3) ? 4'h2 : 4'h3;
        end_wait = (step == 2'd3) ? CW'(CMD_WAIT) : CW'(INIT_WAIT);
      end
      S_CFG: begin
        case (step)
          2'd0:    cur_byte = 8'h28;
          2'd1:    cur_byte = 8'h06;
          2'd2:    cur_byte = 8'h0C;
          default: begin
            cur_byte = 8'h01;
            end_wait = CW'(CLEAR_WAIT);
          end
        endcase
      end
      S_ADDR1: cur_byte = 8'h80;
      S_ADDR2: cur_byte = 8'hC0;
      S_LINE1, S_LINE2: begin
        cur_byte = frame[{~idx, 3'b111} -: 8];
        cur_rs   = 1'b1;
      end
      default: ;
    endcase
    nibble   = nib_only ? wake_nib : (lo ? cur_byte[3:0] : cur_byte[7:4]);
    wait_len = (!nib_only && !lo) ? CW'(NIBBLE_GAP) : end_wait;
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    lo_n      = lo;
    step_n    = step;
    idx_n     = idx;
    cnt_n     = cnt;
    pending_n = pending;
    load      = 1'b0;
    // DONE and IDLE react to refresh directly; LATCH serves it by sampling now.
    if (refresh && state != S_IDLE && state != S_LATCH && state != S_DONE) pending_n = 1'b1;
    case (state)
      S_POWERUP: begin
        if (cnt == CW'(POWERUP_CYCLES - 1)) begin
          state_n = S_WAKE;
          phase_n = P_SETUP;
          cnt_n   = '0;
          step_n  = 2'd0;
          lo_n    = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_LATCH: begin
        load      = 1'b1;
        pending_n = 1'b0;
        state_n   = S_ADDR1;
        phase_n   = P_SETUP;
        lo_n      = 1'b0;
        cnt_n     = '0;
        idx_n     = 5'd0;
      end
      S_DONE: begin
        idx_n     = 5'd0;
        pending_n = 1'b0;
        state_n   = (pending || refresh) ? S_LATCH : S_IDLE;
      end
      S_IDLE: begin
        if (refresh) state_n = S_LATCH;
      end
      default: begin
        case (phase)
          P_SETUP: begin
            phase_n = P_PULSE;
            cnt_n   = '0;
          end
          P_PULSE: begin
            if (cnt == CW'(E_PULSE_CYCLES - 1)) begin
              phase_n = P_HOLD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          P_HOLD: begin
            phase_n = P_WAIT;
            cnt_n   = '0;
          end
          default: begin
            if (cnt == wait_len - 1'b1) begin
              cnt_n   = '0;
              phase_n = P_SETUP;
              if (!nib_only && !lo) begin
                lo_n = 1'b1;
              end else begin
                lo_n = 1'b0;
                case (state)
                  S_WAKE: begin
                    if (step == 2'd3) begin
                      state_n = S_CFG;
                      step_n  = 2'd0;
                    end else begin
                      step_n = step + 2'd1;
                    end
                  end
                  S_CFG: begin
                    if (step == 2'd3) state_n = S_LATCH;
                    else step_n = step + 2'd1;
                  end
                  S_ADDR1: state_n = S_LINE1;
                  S_LINE1: begin
                    if (idx == 5'd15) begin
                      state_n = S_ADDR2;
                      idx_n   = 5'd16;
                    end else begin
                      idx_n = idx + 5'd1;
                    end
                  end
                  S_ADDR2: state_n = S_LINE2;
                  default: begin
                    if (idx == 5'd31) state_n = S_DONE;
                    else idx_n = idx + 5'd1;
                  end
                endcase
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
    lcd_rw     = 1'b0;
    lcd_e      = xfer_state && (phase == P_PULSE);
    lcd_rs     = xfer_state ? cur_rs : 1'b0;
    lcd_dat    = xfer_state ? nibble : 4'h0;
  end

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver with shortened timing: every e-pulse is matched
// against an expected {rs,nibble} queue and its width/stability is checked.
module tb_lcd_char_driver;

  localparam int E_PULSE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         refresh;
  logic [255:0] strdata;
  logic         busy, frame_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0]   lcd_dat;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int done_cnt  = 0;

  logic [4:0] exp_q[$];

  lcd_char_driver #(
    .POWERUP_CYCLES(20), .INIT_WAIT(10), .E_PULSE_CYCLES(E_PULSE),
    .NIBBLE_GAP(3), .CMD_WAIT(5), .CLEAR_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .strdata(strdata),
    .busy(busy), .frame_done(frame_done), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_dat(lcd_dat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic push_frame(input logic [255:0] t);
    push_byte(1'b0, 8'h80);
    for (int k = 0; k < 16; k++) push_byte(1'b1, t[255-8*k -: 8]);
    push_byte(1'b0, 8'hC0);
    for (int k = 16; k < 32; k++) push_byte(1'b1, t[255-8*k -: 8]);
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, frame_done, 1'b1);
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  // Pulse monitor: pops the scoreboard on each rising e, checks width and hold.
  logic [4:0] cap, pre;
  logic       e_prev, unstable;
  int         hi_cnt;
  initial begin
    e_prev = 1'b0;
    pre = '0;
    cap = '0;
    unstable = 1'b0;
    hi_cnt = 0;
  end

  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      pulse_cnt++;
      cap = {lcd_rs, lcd_dat};
      check_eq("rw_low", lcd_rw, 1'b0);
      check_eq("setup_stable", pre, cap);
      if (exp_q.size() == 0) check_eq("pulse_expected", exp_q.size(), 1);
      else check_eq("nibble", cap, exp_q.pop_front());
      hi_cnt = 1;
      unstable = 1'b0;
    end else if (lcd_e) begin
      hi_cnt++;
      if ({lcd_rs, lcd_dat} != cap) unstable = 1'b1;
    end else if (e_prev && !rst) begin
      check_eq("e_width", hi_cnt, E_PULSE);
      check_eq("hold_stable", ({lcd_rs, lcd_dat} == cap) && !unstable, 1'b1);
    end
    if (frame_done) done_cnt++;
    pre = {lcd_rs, lcd_dat};
    e_prev = lcd_e;
  end

  logic [255:0] text1, text_a, text_b, text_c;
  int base, dbase, n;

  initial begin
    text1  = "* Hello World! ** Hello World! *";
    text_a = {32{8'h41}};
    text_b = "bbbbbbbbbbbbbbbbBBBBBBBBBBBBBBBB";
    text_c = "0123456789abcdef!@#$%^&*()-=+_<>";
    rst = 1'b1;
    refresh = 1'b0;
    strdata = text1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_e", lcd_e, 1'b0);
    check_eq("rst_rs", lcd_rs, 1'b0);
    check_eq("rst_rw", lcd_rw, 1'b0);
    check_eq("rst_dat", lcd_dat, 4'h0);
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_done", frame_done, 1'b0);

    // Power-up, init and automatic first frame
    push_init();
    push_frame(text1);
    base = pulse_cnt;
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd_e && n < 100);
    check_eq("first_e_delay", n, 21);
    wait_done(5000, "frame1_timeout");
    check_eq("frame1_pulses", pulse_cnt - base, 80);
    check_eq("frame1_queue", exp_q.size(), 0);
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    repeat ($urandom_range(5, 20)) @(negedge clk);

    // Single refresh from IDLE
    strdata = text_a;
    push_frame(text_a);
    base = pulse_cnt;
    pulse_refresh();
    check_eq("refresh_busy", busy, 1'b1);
    wait_done(3000, "frame_a_timeout");
    check_eq("frame_a_pulses", pulse_cnt - base, 68);
    check_eq("frame_a_queue", exp_q.size(), 0);
    repeat (10) @(negedge clk);

    // Refreshes and a text change during a frame collapse to one more frame
    dbase = done_cnt;
    strdata = text_b;
    push_frame(text_b);
    pulse_refresh();
    repeat (200) @(negedge clk);
    strdata = text_c;
    push_frame(text_c);
    pulse_refresh();
    repeat ($urandom_range(80, 120)) @(negedge clk);
    pulse_refresh();
    repeat ($urandom_range(80, 120)) @(negedge clk);
    pulse_refresh();
    wait_done(3000, "frame_b_timeout");
    @(negedge clk);
    check_eq("busy_across_done", busy, 1'b1);
    wait_done(3000, "frame_c_timeout");
    repeat (60) @(negedge clk);
    check_eq("pending_done_count", done_cnt - dbase, 2);
    check_eq("pending_idle", busy, 1'b0);
    check_eq("pending_queue", exp_q.size(), 0);

    // Reset in the middle of a data pulse
    push_frame(text_c);
    pulse_refresh();
    n = 0;
    while (!(lcd_e && lcd_rs) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("line1_pulse_seen", lcd_e && lcd_rs, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_e", lcd_e, 1'b0);
    check_eq("abort_dat", lcd_dat, 4'h0);
    check_eq("abort_busy", busy, 1'b1);
    push_init();
    push_frame(text_c);
    base = pulse_cnt;
    @(negedge clk);
    rst = 1'b0;
    wait_done(5000, "reinit_timeout");
    check_eq("reinit_pulses", pulse_cnt - base, 80);
    check_eq("reinit_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_char_driver.md
Name: lcd_char_driver

Overview:
- Drives an HD44780-compatible character LCD in 4-bit write-only mode from a 256-bit, 32-character frame: line 1 is chars 0-15, line 2 is chars 16-31.
- Sits directly downstream of the debug-display string formatter, which supplies `strdata` and pulses `refresh` on content change.
- Performs power-on initialisation once, then re-paints the whole frame on every refresh request, without a controller reset.

Parameters:
POWERUP_CYCLES, 1500000, wait after reset before first nibble (15 ms at 100 MHz)
INIT_WAIT, 410000, wait after each of the three 0x3 wake-up nibbles (4.1 ms)
E_PULSE_CYCLES, 25, lcd_e high time per nibble
NIBBLE_GAP, 100, idle cycles between high and low nibble of one byte
CMD_WAIT, 4000, wait after each byte except clear (40 us)
CLEAR_WAIT, 164000, wait after clear command 0x01 (1.64 ms)

Ports:
clk  input  1  system clock; all logic is on posedge
rst  input  1  synchronous, active-high reset
refresh  input  1  request a repaint; level or pulse, sampled each cycle
strdata  input  256  frame text, char 0 = [255:248], char k = [255-8k -: 8]
busy  output  1  high whenever FSM not in IDLE
frame_done  output  1  one-cycle pulse when the last character's CMD_WAIT expires
lcd_e  output  1  LCD enable strobe
lcd_rs  output  1  0 = command, 1 = data
lcd_rw  output  1  constant 0 (write only)
lcd_dat  output  4  LCD D7..D4

Behaviour:
- Reset (rst=1 at posedge):
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_dat=0, busy=1, frame_done=0.
  - Pending flag cleared; wait counter cleared; FSM enters POWERUP.
  - Reset asserted mid-operation aborts immediately, including mid-pulse: lcd_e drops on the next cycle.
- Nibble transaction, one unit:
  - 1 setup cycle: rs/dat valid, e=0.
  - E_PULSE_CYCLES cycles with e=1.
  - 1 hold cycle: e=0, rs/dat unchanged.
  - Then the following wait is counted.
- Byte transaction:
  - High nibble, NIBBLE_GAP, low nibble.
  - Then CMD_WAIT, or CLEAR_WAIT for 0x01.
- FSM sequence:
  - POWERUP: count POWERUP_CYCLES.
  - WAKE: nibble 0x3 (rs=0) three times, INIT_WAIT after each; then nibble 0x2 followed by CMD_WAIT.
  - CFG: command bytes 0x28, 0x06, 0x0C, 0x01 in that order.
  - LATCH: strdata copied into an internal frame register in a single cycle.
  - ADDR1: command byte 0x80.
  - LINE1: data bytes for chars 0..15 (rs=1).
  - ADDR2: command byte 0xC0.
  - LINE2: data bytes for chars 16..31.
  - DONE: frame_done=1 for one cycle.
  - IDLE.
- After CFG the first frame is painted automatically; no refresh is required.
- IDLE: refresh=1 moves the FSM to LATCH on the next cycle. busy rises on that same edge.
- Refresh while busy:
  - Sets the pending flag; it is not lost.
  - On DONE, if pending=1: clear pending and go to LATCH instead of IDLE (busy stays 1).
  - Several refreshes within one frame collapse into a single repaint.
  - Refresh in the same cycle as DONE also counts as pending.
- Refresh during POWERUP/WAKE/CFG is absorbed: the automatic first frame serves it, and pending is cleared at the first LATCH.
- strdata is sampled only in LATCH; changes during a frame do not appear until the next frame.
- Character index counter: 5 bits, wraps from 31 to 0 only via DONE. Wait counter width is sized from the largest parameter.
- lcd_rw is 0 in every state.

Test Plan:
1. Small params (POWERUP=20, INIT_WAIT=10, E_PULSE=2, NIBBLE_GAP=3, CMD_WAIT=5, CLEAR_WAIT=15); release reset and hold refresh=0 -> first lcd_e rise exactly 21 cycles after reset release with dat=0x3, rs=0. Exactly 80 e-pulses occur before frame_done (4 wake + 8 cfg + 4 addr + 64 data).
2. strdata="* Hello World! ** Hello World! *" -> rs=1 nibble pairs in order 0x2,0xA ('*'), 0x2,0x0 (' '), 0x4,0x8 ('H'), ... Command 0xC0 is sent after the 16th char; the final pair is 0x2,0xA.
3. After the frame, set strdata to all "A" and pulse refresh for 1 cycle in IDLE -> busy=1 next cycle, no wake/cfg pulses, 68 pulses: 0x8,0x0, then 16 x (0x4,0x1), then 0xC,0x0, then 16 x (0x4,0x1).
4. Three refresh pulses during one frame, plus a strdata change mid-frame -> the current frame completes with the old text, then exactly one further frame with the new text; busy stays 1 across DONE; exactly 2 frame_done pulses.
5. Assert rst while lcd_e=1 in LINE1 -> next cycle lcd_e=0, lcd_dat=0, busy=1; the full POWERUP/WAKE/CFG sequence repeats.
6. Check every e-pulse -> lcd_e high for exactly 2 cycles, rs/dat stable from setup through hold, lcd_rw=0 throughout.
